// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and default constants shared by the UART receiver and transmitter.
//   UART_OVERSAMPLE : default sample_tick pulses per bit period
//   UART_DATA_BITS  : default data bits per frame
//   uart_state_e    : receiver frame-tracking state
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // ST_PARITY is only entered when the parity option is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer that brings the asynchronous serial line into the clk
// domain. Both flops reset to 1 so that reset never looks like a start bit.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start + DATA_BITS (LSB first) + optional even
// parity + one stop bit. The line is sampled at the middle of each bit,
// counted in sample_tick pulses from the detected falling start edge.
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after
// the data bits and to add the parity_err output.
//
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high reset
//   sample_tick : one-clk pulse at OVERSAMPLE x baud; all state frozen while low
//   rxd         : asynchronous serial input, idle high
//   rx_data     : received word, bit 0 = first data bit on the line
//   rx_valid    : rx_data holds an unconsumed word
//   rx_ready    : consumer accepts rx_data
//   frame_err   : one-clk pulse when the stop bit samples low
//   overrun     : one-clk pulse when a completed word is dropped
//   parity_err  : (option) one-clk pulse when a good-stop frame fails parity
//   dbg_state   : current receiver state, for observation only
//
// Handshake: a word transfers on every clk edge where rx_valid and rx_ready
// are both high; rx_valid then drops on that edge unless a new word lands in
// the same cycle. rx_ready is ignored while rx_valid is low. rx_data never
// changes while rx_valid is high and the word has not been taken.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output uart_state_e          dbg_state
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rxd_s;

    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
    logic                 parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    // Bits arrive LSB first, so each new bit enters at the top and the first
    // bit ends up in bit 0 after DATA_BITS shifts.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (sample_tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rxd_s) begin
                            state_q <= ST_START;
                            cnt_q   <= '0;
                        end
                    end

                    // Re-check the line half a bit later; a high line means
                    // the falling edge was a glitch.
                    ST_START: begin
                        if (cnt_q == MID_CNT) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= rxd_s ? ST_IDLE : ST_DATA;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end

                    // From the mid-start point, a full bit period lands on the
                    // middle of every following bit.
                    ST_DATA: begin
                        if (cnt_q == FULL_CNT) begin
                            cnt_q   <= '0;
                            shift_q <= shift_d;
                            if (bit_q == LAST_BIT) begin
                                bit_q   <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (cnt_q == FULL_CNT) begin
                            cnt_q   <= '0;
                            par_q   <= rxd_s;
                            state_q <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
`endif

                    // Return to IDLE right at mid-stop so the remaining half
                    // stop bit is spent already hunting for the next start.
                    ST_STOP: begin
                        if (cnt_q == FULL_CNT) begin
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                            if (rxd_s) begin
                                // Same-cycle consumption frees the slot, so
                                // only an untaken word blocks the new one.
                                if (rx_valid_q && !rx_ready) begin
                                    overrun_q <= 1'b1;
                                end else begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                parity_err_q <= (^shift_q) ^ par_q;
`endif
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
    assign dbg_state  = state_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: sample_tick pulses per bit period; even, at least 8.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, range 5..8.
REQ-003 SHALL have port clk, input, 1: single system clock, rising edge (49.152 MHz in product).
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sample_tick, input, 1: one-clk pulse at OVERSAMPLE x baud, clk domain.
REQ-006 SHALL have port rxd, input, 1: asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data, output, DATA_BITS: received byte, LSB = first data bit.
REQ-008 SHALL have port rx_valid, output, 1: rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ready, input, 1: consumer accepts rx_data when rx_valid and rx_ready are both high at a clk edge.
REQ-010 SHALL have port frame_err, output, 1: one-clk pulse when the stop bit samples low.
REQ-011 SHALL have port overrun, output, 1: one-clk pulse when a completed byte is dropped.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, STOP (plus PARITY, REQ-024); the tick counter (width clog2(OVERSAMPLE)) and bit index advance only on sample_tick.
REQ-014 IDLE: on a tick with synchronized rxd=0, go to START and clear the tick counter.
REQ-015 START: at tick count OVERSAMPLE/2-1, sample rxd; 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, no output).
REQ-016 DATA: sample one bit every OVERSAMPLE ticks after the mid-start point, shift in LSB first; after bit DATA_BITS-1 go to STOP (or PARITY).
REQ-017 STOP: sample mid-stop; 1 -> good frame; 0 -> frame_err pulse, byte discarded; in both cases go to IDLE immediately after the sample.
REQ-018 A good frame SHALL load rx_data and assert rx_valid on the clk edge following the mid-stop sampling tick (1-cycle latency).
REQ-019 rx_valid SHALL hold, with rx_data stable, until consumed; consumption clears rx_valid on the next edge.
REQ-020 A good frame completing while rx_valid=1 and not consumed that cycle SHALL pulse overrun, drop the new byte and keep the old one.
REQ-021 A good frame completing in the same cycle as consumption SHALL load the new byte with rx_valid staying 1 and no overrun.
REQ-022 sample_tick deasserted SHALL freeze all state; rx_ready SHALL have no effect while rx_valid=0.

Reset
REQ-023 On reset: state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, frame_err 0, overrun 0 (and parity_err 0); a frame in progress SHALL be abandoned without any output pulse.

Configuration
REQ-024 With UART_RX_PARITY_EN defined: an even-parity bit SHALL follow the data bits (PARITY state, sampled like a data bit), output parity_err (1 bit) SHALL pulse with the good-stop result when parity mismatches, and the byte SHALL still be delivered.
REQ-025 Without UART_RX_PARITY_EN: no PARITY state, no parity_err port, frame is start + DATA_BITS + stop.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum type and the default OVERSAMPLE and DATA_BITS constants, shared with the transmitter.
REQ-027 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1; everything else is inline.

Verification
REQ-028 Frame 0xA5, stop=1, OVERSAMPLE=16, tick every 160 clk -> rx_data=0xA5, rx_valid=1 one clk after mid-stop tick, no error pulses.
REQ-029 rxd low for 4 ticks then high -> START aborts to IDLE; rx_valid, frame_err and overrun stay 0.
REQ-030 Frame 0x3C with stop=0 -> one-cycle frame_err pulse, rx_valid stays 0; next good frame 0x55 is received correctly.
REQ-031 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun pulses once; rx_ready=1 at the completion cycle of 0x22 -> rx_data=0x22, no overrun.
REQ-032 reset asserted for 1 clk mid-DATA of 0xFF -> all outputs at reset values, no pulse; next frame 0x81 is received correctly.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_data=0x07, rx_valid=1, parity_err pulses once.
